// File: rtl/fg_config_loader_if.sv
// fg_config_loader_if: framed byte stream into the config loader
interface fg_config_loader_if;
    logic [7:0] data;
    logic       dataValid;
    logic       dataReady;
    logic       frameStart;
    modport master(output data, dataValid, frameStart, input dataReady);
    modport slave(input data, dataValid, frameStart, output dataReady);
endinterface

// File: rtl/fg_config_loader.sv
// fg_config_loader: assembles a shadow CR bus from framed bytes and commits it atomically,
// optionally aligned to the generator sample strobe
module fg_config_loader #(
    parameter int                             CONFIG_REG_BITWIDTH = 64,
    parameter bit                             SYNC_COMMIT         = 1'b1,
    parameter int                             TIMEOUT_CYCLES      = 255,
    parameter logic [CONFIG_REG_BITWIDTH-1:0] RESET_CONFIG        = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_n,
    fg_config_loader_if.slave              cfg,
    input  logic                           sampleStrb_i,
    output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
    output logic                           outputEnable_o,
    output logic                           commitDone_o,
    output logic                           frameError_o,
    output logic                           busy_o
);
    localparam int CBW    = CONFIG_REG_BITWIDTH;
    localparam int NBYTES = CBW / 8;
    localparam int CNTW   = $clog2(NBYTES) + 1;
    localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT_WAIT} state_t;

    state_t           r_state, w_state;
    logic [CNTW-1:0]  r_cnt, w_cnt;
    logic [TW-1:0]    r_to, w_to;
    logic [2:0]       r_cmd, w_cmd;
    logic [CBW-1:0]   r_shadow, w_shadow, r_cr, w_cr;
    logic             r_oe, w_oe, r_done, w_done, r_err, w_err;
    logic             w_acc;

    assign cfg.dataReady  = rst_n && r_state != COMMIT_WAIT;
    assign w_acc          = cfg.dataValid && cfg.dataReady;
    assign CR_bus_o       = r_cr;
    assign outputEnable_o = r_oe;
    assign commitDone_o   = r_done;
    assign frameError_o   = r_err;
    assign busy_o         = r_state != IDLE;

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_to     = r_to;
        w_cmd    = r_cmd;
        w_shadow = r_shadow;
        w_cr     = r_cr;
        w_oe     = r_oe;
        w_done   = 1'b0;
        w_err    = 1'b0;
        // frameStart overrides everything; a byte taken with it is a fresh command
        if (cfg.frameStart || r_state == IDLE) begin
            w_state = IDLE;
            w_cnt   = '0;
            w_to    = '0;
            w_err   = cfg.frameStart && r_state != IDLE;
            if (w_acc) begin
                if (cfg.data[7:4] == 4'hA) begin
                    w_cmd   = cfg.data[2:0];
                    w_state = cfg.data[1] ? LOAD : COMMIT_WAIT;
                end else begin
                    w_err = 1'b1;
                end
            end
        end else if (r_state == LOAD) begin
            if (w_acc) begin
                for (int k = 0; k < NBYTES; k++)
                    if (r_cnt == CNTW'(k)) w_shadow[CBW-1-8*k -: 8] = cfg.data;
                w_to  = '0;
                w_cnt = r_cnt + CNTW'(1);
                if (r_cnt == CNTW'(NBYTES - 1)) begin
                    w_state = COMMIT_WAIT;
                    w_cnt   = '0;
                end
            end else if (r_to == TW'(TIMEOUT_CYCLES - 1)) begin
                w_err   = 1'b1;
                w_state = IDLE;
                w_to    = '0;
                w_cnt   = '0;
            end else begin
                w_to = r_to + TW'(1);
            end
        end else if (!SYNC_COMMIT || !r_oe || sampleStrb_i) begin
            w_oe    = r_cmd[0];
            w_cr    = r_cmd[2] ? r_shadow : r_cr;
            w_done  = 1'b1;
            w_state = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_to     <= '0;
            r_cmd    <= '0;
            r_shadow <= RESET_CONFIG;
            r_cr     <= RESET_CONFIG;
            r_oe     <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_to     <= w_to;
            r_cmd    <= w_cmd;
            r_shadow <= w_shadow;
            r_cr     <= w_cr;
            r_oe     <= w_oe;
            r_done   <= w_done;
            r_err    <= w_err;
        end
    end
endmodule
